// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: load-use stalls, branch flushes,
// multi-cycle MDU occupancy of EX, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 3,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_e,
    input  logic             load_e,
    input  logic             pc_src_e,
    input  logic             mdu_start_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          busy;
    logic          lw;
    logic          done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // MDU occupancy sequencer: the issue cycle plus MDU_LAT-2 counted cycles stall EX,
    // the final cycle reports done and lets the next op be accepted immediately after.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (mdu_start_e && !pc_src_e) begin
                    state_next = BUSY;
                    cnt_next   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CW'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = ((state == IDLE) && mdu_start_e && !pc_src_e) ||
               ((state == BUSY) && (cnt != '0));
        done = (state == BUSY) && (cnt == '0);
        lw   = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        mdu_busy = 1'b0;
        mdu_done = 1'b0;

        if (!clr) begin
            mdu_busy = busy;
            mdu_done = done;
            // An MDU op in EX must not be cleared by a load-use hazard; bubble goes to M instead.
            if (busy) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                flush_m = 1'b1;
            end else if (pc_src_e) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lw) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            stall_cnt <= '0;
        end else if (stall_f) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule
